// File: rtl/controle_jogo_param.sv
// ---------------------------------------------------------------------------
// controle_jogo_param
//
// Memory-game control unit with its own datapath. The player builds the
// sequence: after each correct repetition a new item is appended. The FSM
// shows the stored sequence on the LEDs, waits for the player to repeat it,
// compares every press and finishes in ACERTO, ERRO or TIMEOUT.
//
// Parameters
//   N_BOTOES       number of buttons/LEDs (2..16)
//   MAX_RODADAS    sequence length that wins the game (1..64)
//   LED_CICLOS     cycles an LED stays lit / dark between items
//   TIMEOUT_CICLOS cycles allowed for each player press
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-low reset
//   iniciar       start/restart request (level)
//   modo_dificil  difficulty select, latched in PREPARA
//   botoes        raw button levels, synchronous to clock
//   leds          one-hot LED drive or all zero
//   vez_jogador   player's turn (ESPERA / ADICIONA)
//   acertou       game won
//   errou         wrong button pressed
//   timeout       player took too long
//   pronto        game over (any of the three final states)
//   rodada        current stored sequence length
//   db_estado     state code for debug
//   db_endereco   sequence address for debug
// ---------------------------------------------------------------------------
module controle_jogo_param #(
    parameter int N_BOTOES       = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int LED_CICLOS     = 1000,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int IW = $clog2(N_BOTOES),
    localparam int RW = $clog2(MAX_RODADAS + 1),
    localparam int AW = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo_dificil,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                vez_jogador,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic                pronto,
    output logic [RW-1:0]       rodada,
    output logic [3:0]          db_estado,
    output logic [AW-1:0]       db_endereco
);

    // Difficult mode halves both durations but never below one cycle.
    localparam int LED_DIF = ((LED_CICLOS / 2) < 1) ? 1 : (LED_CICLOS / 2);
    localparam int TO_DIF  = ((TIMEOUT_CICLOS / 2) < 1) ? 1 : (TIMEOUT_CICLOS / 2);
    localparam int MAXD    = (LED_CICLOS > TIMEOUT_CICLOS) ? LED_CICLOS : TIMEOUT_CICLOS;
    localparam int TW      = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        CARREGA     = 4'd2,
        MOSTRA      = 4'd3,
        APAGA       = 4'd4,
        ESPERA      = 4'd5,
        REGISTRA    = 4'd6,
        COMPARA     = 4'd7,
        PROXIMO     = 4'd8,
        ADICIONA    = 4'd9,
        PROX_RODADA = 4'd10,
        ACERTO      = 4'd11,
        ERRO        = 4'd12,
        TIMEOUT     = 4'd13
    } estado_t;

    estado_t       estado;
    logic [RW-1:0] tamanho;
    logic [AW-1:0] endereco;
    logic [TW-1:0] led_cnt;
    logic [TW-1:0] to_cnt;
    logic          modo_q;
    logic          any_q;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] mem [MAX_RODADAS];

    logic          jogada;
    logic [TW-1:0] led_fim;
    logic [TW-1:0] to_fim;
    logic          led_exp;
    logic          to_exp;
    logic          is_last;
    logic [IW-1:0] mem_atual;
    logic          mem_we;

    // A press only counts on the first cycle of activity after every button
    // has been released, so holding a button never produces a second press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |botoes;
        end
    end

    assign jogada = (|botoes) & ~any_q;

    // Lowest-numbered pressed button wins when several are held together.
    always_comb begin
        idx = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (botoes[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign led_fim   = modo_q ? TW'(LED_DIF - 1) : TW'(LED_CICLOS - 1);
    assign to_fim    = modo_q ? TW'(TO_DIF - 1)  : TW'(TIMEOUT_CICLOS - 1);
    assign led_exp   = (led_cnt == led_fim);
    assign to_exp    = (to_cnt == to_fim);
    assign mem_atual = mem[endereco];
    assign is_last   = ((RW'(endereco) + RW'(1)) == tamanho);
    assign mem_we    = (estado == ADICIONA) && jogada;

    // Sequence memory: written only when the player appends an item; its
    // contents survive reset because a new game always rebuilds it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[tamanho[AW-1:0]] <= idx;
        end
    end

    // Main FSM together with the counters and the registered LED drive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            tamanho  <= '0;
            endereco <= '0;
            led_cnt  <= '0;
            to_cnt   <= '0;
            modo_q   <= 1'b0;
            idx_q    <= '0;
            leds     <= '0;
        end else begin
            case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        estado <= PREPARA;
                    end
                end
                PREPARA: begin
                    tamanho  <= '0;
                    endereco <= '0;
                    modo_q   <= modo_dificil;
                    to_cnt   <= '0;
                    leds     <= '0;
                    estado   <= ADICIONA;
                end
                CARREGA: begin
                    leds    <= N_BOTOES'(1) << mem_atual;
                    led_cnt <= '0;
                    estado  <= MOSTRA;
                end
                MOSTRA: begin
                    if (led_exp) begin
                        leds    <= '0;
                        led_cnt <= '0;
                        estado  <= APAGA;
                    end else begin
                        led_cnt <= led_cnt + TW'(1);
                    end
                end
                APAGA: begin
                    if (led_exp) begin
                        led_cnt <= '0;
                        if (is_last) begin
                            endereco <= '0;
                            to_cnt   <= '0;
                            estado   <= ESPERA;
                        end else begin
                            endereco <= endereco + AW'(1);
                            estado   <= CARREGA;
                        end
                    end else begin
                        led_cnt <= led_cnt + TW'(1);
                    end
                end
                ESPERA: begin
                    // A press on the expiry cycle still counts as a press.
                    if (jogada) begin
                        idx_q  <= idx;
                        estado <= REGISTRA;
                    end else if (to_exp) begin
                        estado <= TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                REGISTRA: begin
                    estado <= COMPARA;
                end
                COMPARA: begin
                    if (idx_q != mem_atual) begin
                        estado <= ERRO;
                    end else if (!is_last) begin
                        estado <= PROXIMO;
                    end else if (tamanho == RW'(MAX_RODADAS)) begin
                        estado <= ACERTO;
                    end else begin
                        to_cnt <= '0;
                        estado <= ADICIONA;
                    end
                end
                PROXIMO: begin
                    endereco <= endereco + AW'(1);
                    to_cnt   <= '0;
                    estado   <= ESPERA;
                end
                ADICIONA: begin
                    if (jogada) begin
                        tamanho <= tamanho + RW'(1);
                        estado  <= PROX_RODADA;
                    end else if (to_exp) begin
                        estado <= TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                PROX_RODADA: begin
                    endereco <= '0;
                    estado   <= CARREGA;
                end
                ACERTO, ERRO, TIMEOUT: begin
                    if (iniciar) begin
                        estado <= PREPARA;
                    end
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    // Status flags are pure decodes of the registered state.
    assign vez_jogador = (estado == ESPERA) || (estado == ADICIONA);
    assign acertou     = (estado == ACERTO);
    assign errou       = (estado == ERRO);
    assign timeout     = (estado == TIMEOUT);
    assign pronto      = (estado == ACERTO) || (estado == ERRO) || (estado == TIMEOUT);
    assign rodada      = tamanho;
    assign db_estado   = estado;
    assign db_endereco = endereco;

endmodule

// File: doc/controle_jogo_param.md
Name: controle_jogo_param

Overview:
- Parametrised successor of the memory-game control unit: FSM plus its own datapath.
- Owns the sequence memory, address and length counters, LED and timeout timers, and button-press detection.
- Generalised to N buttons/LEDs, configurable maximum rounds, and a difficulty mode.
- Plays a player-built sequence: each round the sequence is shown, the player repeats it, then appends one new play.

Parameters:
- N_BOTOES, 4: number of buttons/LEDs (2..16). IW = clog2(N_BOTOES).
- MAX_RODADAS, 16: sequence length that wins the game (1..64). RW = clog2(MAX_RODADAS+1).
- LED_CICLOS, 1000: cycles an LED is lit, and also cycles it stays dark between items (normal mode).
- TIMEOUT_CICLOS, 5000: cycles allowed per player press (normal mode).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request, level
- modo_dificil  in  1  difficulty select, sampled in PREPARA
- botoes  in  N_BOTOES  raw button levels, synchronous to clock
- leds  out  N_BOTOES  one-hot LED drive, or all zero
- vez_jogador  out  1  high in ESPERA and ADICIONA
- acertou  out  1  high in ACERTO
- errou  out  1  high in ERRO
- timeout  out  1  high in TIMEOUT
- pronto  out  1  high in ACERTO, ERRO or TIMEOUT
- rodada  out  RW  current stored sequence length
- db_estado  out  4  state code
- db_endereco  out  IW' = clog2(MAX_RODADAS)  sequence address (minimum 1 bit)

Behaviour:
- reset low: asynchronously forces INICIAL. All outputs 0; all counters 0; modo register 0; press-detect register 0. Memory contents are not reset.
- Press event (jogada):
  - Registered flag any_q <= |botoes; jogada = |botoes & ~any_q.
  - Index = lowest set bit of botoes in that cycle.
  - A new press requires all buttons released for at least one cycle.
- Effective durations:
  - Normal mode: LED_CICLOS and TIMEOUT_CICLOS.
  - modo_dificil latched 1: each duration is halved (>>1), minimum 1.
- Timers count 0..D-1. Expiry is the cycle in which count == D-1.
- State codes: INICIAL 0, PREPARA 1, CARREGA 2, MOSTRA 3, APAGA 4, ESPERA 5, REGISTRA 6, COMPARA 7, PROXIMO 8, ADICIONA 9, PROX_RODADA 10, ACERTO 11, ERRO 12, TIMEOUT 13. Codes 14–15 are illegal and go to INICIAL.
- Transitions:
  - INICIAL: iniciar -> PREPARA.
  - PREPARA: tamanho=0, endereco=0, latch modo, clear timeout timer -> ADICIONA.
  - CARREGA: leds <= onehot(mem[endereco]); clear LED timer -> MOSTRA.
  - MOSTRA: leds held. LED expiry -> APAGA, with leds cleared and LED timer cleared.
  - APAGA: leds 0. On LED expiry:
    - if endereco == tamanho-1: endereco=0, clear timeout timer -> ESPERA;
    - else endereco++ -> CARREGA.
  - ESPERA: timeout timer runs.
    - jogada -> REGISTRA, latching the index.
    - Otherwise timeout expiry -> TIMEOUT.
    - If both occur in the same cycle, jogada wins.
  - REGISTRA -> COMPARA.
  - COMPARA:
    - latched index != mem[endereco] -> ERRO;
    - match and endereco < tamanho-1 -> PROXIMO;
    - match and last item and tamanho == MAX_RODADAS -> ACERTO;
    - match and last item otherwise -> ADICIONA, clearing the timeout timer.
  - PROXIMO: endereco++, clear timeout timer -> ESPERA.
  - ADICIONA: timeout timer runs. jogada -> write mem[tamanho] <= index, tamanho++ -> PROX_RODADA. Timeout expiry with no jogada -> TIMEOUT.
  - PROX_RODADA: endereco=0 -> CARREGA.
  - ACERTO, ERRO, TIMEOUT: hold all flags. iniciar -> PREPARA, which restarts with tamanho=0.
- First round: the player enters the first item in ADICIONA; the sequence of length 1 is then shown.
- Buttons pressed outside ESPERA/ADICIONA are ignored. any_q still tracks them, so a press held through the state entry does not register.
- iniciar is ignored outside INICIAL and the final states.
- Counters never wrap:
  - tamanho is bounded by MAX_RODADAS because ADICIONA is unreachable at the maximum.
  - endereco is bounded by tamanho-1.
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.

Test Plan:
Bench parameters: N_BOTOES=4, MAX_RODADAS=3, LED_CICLOS=4, TIMEOUT_CICLOS=10.
1. Win:
   - Stimulus: after reset release, pulse iniciar; add button 2; repeat 2, add 0; repeat 2,0, add 3; repeat 2,0,3.
   - Required: ACERTO, acertou=1, pronto=1, rodada=3.
   - Required during display: leds show 0100, 0001, 1000, each for 4 cycles with 4 dark cycles between.
2. Wrong button:
   - Stimulus: sequence [1]; player presses button 3.
   - Required: ERRO two cycles after the press edge, errou=1, pronto=1, acertou=0.
3. Timeout:
   - Stimulus: no press in ESPERA.
   - Required: TIMEOUT entered on the 10th ESPERA cycle, timeout=1.
   - Second run: press edge exactly on the expiry cycle -> REGISTRA, not TIMEOUT.
4. Difficult mode:
   - Stimulus: modo_dificil=1 at PREPARA.
   - Required: LED lit 2 cycles, dark 2 cycles; timeout after 5 cycles.
   - Toggling modo_dificil mid-game has no effect.
5. Button handling:
   - Stimulus: hold button 1 for 20 cycles, then simultaneously press 0011 after a release.
   - Required: the held press registers one jogada only; 0011 registers index 0.
6. Reset mid-operation:
   - Stimulus: assert reset low during MOSTRA.
   - Required: same cycle, without waiting for an edge: db_estado=0, leds=0, rodada=0.
   - After release with iniciar: fresh game, rodada=0, enters ADICIONA.
